rsa_seq_ctrl: RTL and testbench
===============================

Name: rsa_seq_ctrl

Overview:
- Sequencer for the 256-bit RSA modular-exponentiation core (a0 = a1^a2 mod a3).
- Accepts a little-endian byte stream from the host link and loads it into the core over the core's 8-bit reg_sel/addr bus: 32 bytes N (modulus), then 32 bytes M (base), then 32 bytes E (exponent).
- Pulses start, waits for completion, then reads the 32-byte result and streams it out with a valid/ready handshake.

Parameters:
- NBYTES, 32, bytes per operand; must equal 2^ADDR_W.
- ADDR_W, 5, core address width.
- BUSY_TIMEOUT, 1024, cycles allowed for core_busy to rise after start (used only with the optional feature).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- in_data, in, 8, host operand byte.
- in_valid, in, 1, in_data valid.
- in_ready, out, 1, controller accepts byte this cycle.
- out_data, out, 8, result byte.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, host accepts result byte.
- done, out, 1, one-cycle pulse after the last result byte is accepted.
- err, out, 1, one-cycle pulse on timeout abort (optional feature only, else tied 0).
- core_reg_sel, out, 2, core register select: 3=N, 1=M, 2=E, 0=result.
- core_addr, out, ADDR_W, core byte address.
- core_wdata, out, 8, to core data_i.
- core_rdata, in, 8, from core data_o (registered in core, 1-cycle read latency).
- core_we_n, out, 1, active-low write strobe.
- core_oe_n, out, 1, active-low read strobe.
- core_start_n, out, 1, active-low start.
- core_busy, in, 1, core "ready" output (high while computing).

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low.
- Reset values (all outputs): in_ready=0, out_valid=0, out_data=0, done=0, err=0, core_we_n=1, core_oe_n=1, core_start_n=1, core_reg_sel=0, core_addr=0, core_wdata=0.
- Registered outputs: all core_* outputs are flops, with no combinational path from inputs to core_*.
- Byte counter: cnt, ADDR_W bits, 0..NBYTES-1.
- IDLE: in_ready=0. Go to LOAD_N next cycle, cnt=0.
- LOAD_N / LOAD_M / LOAD_E:
  - in_ready=1.
  - On in_valid&&in_ready: the next cycle drives core_we_n=0, core_reg_sel=3/1/2, core_addr=cnt, core_wdata=in_data. cnt increments.
  - Without an accept, core_we_n=1 the next cycle.
  - Back-to-back accepts give one write per cycle.
  - When cnt=NBYTES-1 is accepted, cnt wraps to 0 and the state advances N->M->E->START. in_ready drops to 0 in the cycle after the final E byte.
- START:
  - Waits one cycle so the last write completes.
  - Then drives core_start_n=0 for exactly 1 cycle and goes to WAIT_BUSY.
- WAIT_BUSY: waits for core_busy=1, then goes to WAIT_DONE.
- WAIT_DONE: waits for core_busy=0, then goes to READ_ADDR with cnt=0.
- READ_ADDR: next cycle drives core_oe_n=0, core_reg_sel=0, core_addr=cnt (1 cycle), then goes to READ_WAIT.
- READ_WAIT:
  - Lasts 2 cycles: the strobe cycle, then the core data_o update.
  - On exit, captures core_rdata into out_data and goes to SEND.
- SEND:
  - out_valid=1; out_data holds stable until out_ready.
  - On out_valid&&out_ready:
    - if cnt=NBYTES-1: pulse done, go to IDLE;
    - else: cnt+1, go to READ_ADDR.
  - out_valid deasserts the cycle after acceptance.
- Simultaneous events:
  - in_valid is ignored outside LOAD states (in_ready=0).
  - out_ready is ignored when out_valid=0.
  - core_busy high while in a LOAD state is ignored.
- Reset mid-operation: immediate return to reset values. A partial operand load is discarded, and the next session restarts at N byte 0.
- Result byte order: address 0 first (little-endian).

Optional Feature:
- RSA_SEQ_CTRL_TIMEOUT_EN defined:
  - A 16-bit counter runs in WAIT_BUSY.
  - If core_busy is still 0 after BUSY_TIMEOUT cycles: pulse err for 1 cycle, core_start_n=1, go to IDLE without reading.
- Undefined: WAIT_BUSY waits forever; err is constant 0 and the counter is not synthesised.

Test Plan:
- Load N=143, M=2, E=7 (byte 0 = LSB, others 0), with the core model or real core, and out_ready held 1 -> result bytes 0x80 then 31x 0x00, followed by a done pulse. Exactly 96 core_we_n low cycles with reg_sel sequence 3,1,2 and addr 0..31 each. One core_start_n low cycle.
- Load with in_valid toggling every other cycle -> core_addr strictly increments per accepted byte, no duplicate or missing writes, core_wdata matches each accepted in_data.
- Result phase with out_ready low for 5 cycles per byte -> out_data stable while out_valid=1 and out_ready=0. 32 bytes delivered in order; core_oe_n pulsed exactly 32 times.
- Assert reset low at byte 40 of the load, release, then reload a full session -> outputs at reset values during reset; the new session writes N addr 0 first; correct result.
- With RSA_SEQ_CTRL_TIMEOUT_EN, BUSY_TIMEOUT=16, core_busy tied 0 -> err pulses 16 cycles after core_start_n, state returns to IDLE, in_ready=1 one cycle later, no oe pulses.
- Without the macro, same stimulus -> err stays 0 and the controller stays in WAIT_BUSY for 2000 cycles.

Source files
------------

// File: rtl/rsa_seq_ctrl.sv
// Host-to-core sequencer for the 256-bit RSA modexp core: loads N, M, E, starts, reads back the result.
// Optional busy-rise timeout abort is enabled by defining RSA_SEQ_CTRL_TIMEOUT_EN.
module rsa_seq_ctrl #(
    parameter int unsigned NBYTES       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              err,
    output logic [1:0]        core_reg_sel,
    output logic [ADDR_W-1:0] core_addr,
    output logic [7:0]        core_wdata,
    input  logic [7:0]        core_rdata,
    output logic              core_we_n,
    output logic              core_oe_n,
    output logic              core_start_n,
    input  logic              core_busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NBYTES - 1);
    localparam logic [1:0] SEL_RES = 2'd0;
    localparam logic [1:0] SEL_M   = 2'd1;
    localparam logic [1:0] SEL_E   = 2'd2;
    localparam logic [1:0] SEL_N   = 2'd3;

    if (NBYTES != (1 << ADDR_W) || BUSY_TIMEOUT == 0) begin : g_cfg_check
        $error("rsa_seq_ctrl: NBYTES must equal 2**ADDR_W and BUSY_TIMEOUT must be nonzero");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_N,
        S_LOAD_M,
        S_LOAD_E,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_READ_ADDR,
        S_READ_WAIT,
        S_SEND
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              rd_phase, rd_phase_nxt;
    logic              in_ready_nxt, out_valid_nxt, done_nxt, err_nxt;
    logic              we_n_nxt, oe_n_nxt, start_n_nxt;
    logic [7:0]        out_data_nxt, wdata_nxt;
    logic [1:0]        sel_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              accept_in, accept_out;

    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid && out_ready;

`ifdef RSA_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned TMO_W = 16;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Cycles spent waiting for busy to rise; cleared outside WAIT_BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state != S_WAIT_BUSY) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_phase_nxt = 1'b0;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        we_n_nxt     = 1'b1;
        oe_n_nxt     = 1'b1;
        start_n_nxt  = 1'b1;
        sel_nxt      = core_reg_sel;
        addr_nxt     = core_addr;
        wdata_nxt    = core_wdata;
        out_data_nxt = out_data;

        case (state)
            S_IDLE: begin
                state_nxt = S_LOAD_N;
                cnt_nxt   = '0;
            end
            S_LOAD_N, S_LOAD_M, S_LOAD_E: begin
                if (accept_in) begin
                    we_n_nxt  = 1'b0;
                    addr_nxt  = cnt;
                    wdata_nxt = in_data;
                    cnt_nxt   = cnt + ADDR_W'(1);
                    case (state)
                        S_LOAD_N: begin
                            sel_nxt = SEL_N;
                            if (cnt == LAST_IDX) state_nxt = S_LOAD_M;
                        end
                        S_LOAD_M: begin
                            sel_nxt = SEL_M;
                            if (cnt == LAST_IDX) state_nxt = S_LOAD_E;
                        end
                        default: begin
                            sel_nxt = SEL_E;
                            if (cnt == LAST_IDX) state_nxt = S_START;
                        end
                    endcase
                end
            end
            S_START: begin
                // The final E write is on the bus this cycle; start follows it.
                start_n_nxt = 1'b0;
                state_nxt   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (core_busy) begin
                    state_nxt = S_WAIT_DONE;
                end
`ifdef RSA_SEQ_CTRL_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
`endif
            end
            S_WAIT_DONE: begin
                if (!core_busy) begin
                    state_nxt = S_READ_ADDR;
                    cnt_nxt   = '0;
                end
            end
            S_READ_ADDR: begin
                oe_n_nxt  = 1'b0;
                sel_nxt   = SEL_RES;
                addr_nxt  = cnt;
                state_nxt = S_READ_WAIT;
            end
            S_READ_WAIT: begin
                // First cycle is the strobe, second sees the core's registered data.
                if (!rd_phase) begin
                    rd_phase_nxt = 1'b1;
                end else begin
                    out_data_nxt = core_rdata;
                    state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                if (accept_out) begin
                    if (cnt == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        cnt_nxt   = cnt + ADDR_W'(1);
                        state_nxt = S_READ_ADDR;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        in_ready_nxt  = (state_nxt == S_LOAD_N) || (state_nxt == S_LOAD_M) ||
                        (state_nxt == S_LOAD_E);
        out_valid_nxt = (state_nxt == S_SEND);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rd_phase     <= 1'b0;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= 8'd0;
            done         <= 1'b0;
            err          <= 1'b0;
            core_we_n    <= 1'b1;
            core_oe_n    <= 1'b1;
            core_start_n <= 1'b1;
            core_reg_sel <= 2'd0;
            core_addr    <= '0;
            core_wdata   <= 8'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rd_phase     <= rd_phase_nxt;
            in_ready     <= in_ready_nxt;
            out_valid    <= out_valid_nxt;
            out_data     <= out_data_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
            core_we_n    <= we_n_nxt;
            core_oe_n    <= oe_n_nxt;
            core_start_n <= start_n_nxt;
            core_reg_sel <= sel_nxt;
            core_addr    <= addr_nxt;
            core_wdata   <= wdata_nxt;
        end
    end

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Self-checking bench for rsa_seq_ctrl: behavioural RSA core model plus host-side scoreboard.
`timescale 1ns/1ps
module tb_rsa_seq_ctrl;

    localparam int AW  = 5;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          done, err;
    logic [1:0]    core_reg_sel;
    logic [AW-1:0] core_addr;
    logic [7:0]    core_wdata;
    logic [7:0]    core_rdata = 8'd0;
    logic          core_we_n, core_oe_n, core_start_n;
    logic          core_busy;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    rsa_seq_ctrl #(.NBYTES(32), .ADDR_W(AW), .BUSY_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done),
        .err         (err),
        .core_reg_sel(core_reg_sel),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_we_n   (core_we_n),
        .core_oe_n   (core_oe_n),
        .core_start_n(core_start_n),
        .core_busy   (core_busy)
    );

    function automatic logic [255:0] modexp(input logic [255:0] b, input logic [255:0] e,
                                            input logic [255:0] n);
        logic [511:0] r, x, nn;
        nn = {256'd0, n};
        r  = 512'd1 % nn;
        x  = {256'd0, b} % nn;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[255:0];
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r = 256'd0;
        for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
        return r;
    endfunction

    // Core model: byte-addressed operand stores, registered read port, busy window after start.
    logic [255:0] mem_n = 256'd0, mem_m = 256'd0, mem_e = 256'd0, res = 256'd0;
    int   dly = 0, run = 0;
    logic bz = 1'b0, noise = 1'b0, core_dead = 1'b0;
    assign core_busy = bz | noise;

    always @(posedge clk) begin
        if (!core_we_n) begin
            case (core_reg_sel)
                2'd3:    mem_n[32'(core_addr)*8 +: 8] <= core_wdata;
                2'd1:    mem_m[32'(core_addr)*8 +: 8] <= core_wdata;
                2'd2:    mem_e[32'(core_addr)*8 +: 8] <= core_wdata;
                default: ;
            endcase
        end
        if (!core_oe_n)
            core_rdata <= (core_reg_sel == 2'd0) ? res[32'(core_addr)*8 +: 8] : 8'hEE;
        if (!core_start_n) begin
            if (!core_dead) begin
                res <= modexp(mem_m, mem_e, mem_n);
                dly <= $urandom_range(1, 4);
                run <= $urandom_range(2, 40);
            end
        end else if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) bz <= 1'b1;
        end else if (run > 0) begin
            run <= run - 1;
            if (run == 1) bz <= 1'b0;
        end
    end

    // Spurious busy while loading must be ignored by the sequencer.
    always @(negedge clk) noise <= in_ready ? 1'($urandom_range(0, 1)) : 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_in_ready"},  256'(in_ready), 256'd0);
        check({where, "_out_valid"}, 256'(out_valid), 256'd0);
        check({where, "_out_data"},  256'(out_data), 256'd0);
        check({where, "_done"},      256'(done), 256'd0);
        check({where, "_err"},       256'(err), 256'd0);
        check({where, "_we_n"},      256'(core_we_n), 256'd1);
        check({where, "_oe_n"},      256'(core_oe_n), 256'd1);
        check({where, "_start_n"},   256'(core_start_n), 256'd1);
        check({where, "_reg_sel"},   256'(core_reg_sel), 256'd0);
        check({where, "_addr"},      256'(core_addr), 256'd0);
        check({where, "_wdata"},     256'(core_wdata), 256'd0);
    endtask

    // One host session. vmode: 0 always valid, 1 alternate, 2 random.
    // rmode: 0 always ready, 1 five stall cycles per byte, 2 random.
    task automatic run_session(input logic [255:0] n, input logic [255:0] m, input logic [255:0] e,
                               input int vmode, input int rmode, input int abort_at, input bit dead);
        logic [7:0]   op_bytes [96];
        logic [255:0] exp_res;
        int   sent = 0, wr = 0, rcv = 0, we_cnt = 0, st_cnt = 0, oe_cnt = 0;
        int   cyc = 0, hold = 0, since = -1;
        bit   acc_prev = 0, last_sched = 0, fin = 0, stall_prev = 0, err_seen = 0;
        logic [7:0] data_prev = 8'd0;
        int   sel_tab [3] = '{3, 1, 2};

        for (int i = 0; i < 32; i++) begin
            op_bytes[i]      = n[i*8 +: 8];
            op_bytes[32 + i] = m[i*8 +: 8];
            op_bytes[64 + i] = e[i*8 +: 8];
        end
        exp_res   = modexp(m, e, n);
        core_dead = dead;

        while (!fin && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (acc_prev || !core_we_n) check("we_n", 256'(core_we_n), 256'(!acc_prev));
            if (!core_we_n) begin
                we_cnt++;
                if (wr < 96) begin
                    check("wr_sel",  256'(core_reg_sel), 256'(sel_tab[wr / 32]));
                    check("wr_addr", 256'(core_addr), 256'(wr % 32));
                    check("wr_data", 256'(core_wdata), 256'(op_bytes[wr]));
                end
                wr++;
            end
            if (!core_start_n) begin
                st_cnt++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (!core_oe_n) oe_cnt++;
            if (stall_prev) begin
                check("hold_valid", 256'(out_valid), 256'd1);
                check("hold_data",  256'(out_data), 256'(data_prev));
            end
            if (last_sched || done) check("done", 256'(done), 256'(last_sched));
            if (last_sched) fin = 1;
            if (err) err_seen = 1;
            if (dead && since >= 0) begin
`ifdef RSA_SEQ_CTRL_TIMEOUT_EN
                if (since == TMO - 1) check("err_early", 256'(err_seen), 256'd0);
                if (since == TMO) check("err_pulse", 256'(err), 256'd1);
                if (since == TMO + 1) begin
                    check("err_one_cycle", 256'(err), 256'd0);
                    check("reload_ready", 256'(in_ready), 256'd1);
                    fin = 1;
                end
`else
                if (since == 2000) begin
                    check("stuck_err", 256'(err_seen), 256'd0);
                    check("stuck_out_valid", 256'(out_valid), 256'd0);
                    check("stuck_in_ready", 256'(in_ready), 256'd0);
                    fin = 1;
                end
`endif
            end
            if (abort_at > 0 && sent == abort_at) begin
                reset     = 1'b0;
                in_valid  = 1'b0;
                out_ready = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                check_reset_outputs("abort_hold");
                reset = 1'b1;
                return;
            end
            if (fin) break;

            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (sent < 96) ? op_bytes[sent] : 8'($urandom());
            if (sent >= 96 && in_valid) check("in_ready_after_load", 256'(in_ready), 256'd0);
            acc_prev = in_valid && in_ready;
            if (acc_prev && sent < 96) sent++;

            if (out_valid) begin
                case (rmode)
                    0: out_ready = 1'b1;
                    1: begin
                        out_ready = (hold >= 5);
                        hold = (hold >= 5) ? 0 : hold + 1;
                    end
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                hold = 0;
            end
            if (out_valid && out_ready) begin
                if (rcv < 32) check("rx_byte", 256'(out_data), 256'(exp_res[rcv*8 +: 8]));
                rcv++;
                if (rcv == 32) last_sched = 1;
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end

        check("session_complete", 256'(fin), 256'd1);
        check("we_count", 256'(we_cnt), 256'd96);
        check("start_count", 256'(st_cnt), 256'd1);
        if (dead) begin
            check("oe_count", 256'(oe_cnt), 256'd0);
        end else begin
            check("oe_count", 256'(oe_cnt), 256'd32);
            check("rx_count", 256'(rcv), 256'd32);
        end
        core_dead = 1'b0;
    endtask

    task automatic random_session(input int vmode, input int rmode, input int abort_at);
        logic [255:0] n, m, e;
        n = rnd256() | {1'b1, 255'd0} | 256'd1;
        m = rnd256() % n;
        e = rnd256();
        run_session(n, m, e, vmode, rmode, abort_at, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        @(negedge clk);
        check("idle_to_load", 256'(in_ready), 256'd1);

        run_session(256'd143, 256'd2, 256'd7, 0, 0, 0, 1'b0);
        random_session(1, 1, 0);
        random_session(2, 2, 0);
        random_session(2, 2, 40);
        random_session(0, 2, 0);
        random_session(2, 0, 0);
        run_session(256'd143, 256'd2, 256'd7, 0, 0, 0, 1'b1);

        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_stall");
        reset = 1'b1;
        random_session(1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
